// File: rtl/serial_mag_comp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam int SLICE_W = 2;

  function automatic int nslices(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Start/done handshake and operand/result bus of the serial magnitude comparator.
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (output start, a, b, input busy, done, lt, gt, eq);
  modport slave  (input start, a, b, output busy, done, lt, gt, eq);
endinterface

// File: rtl/serial_mag_comp_twobit.sv
// Gate-level 2-bit magnitude comparator used as the per-slice evaluator.
module twobit_com (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic lt,
  output logic gt,
  output logic eq
);
  logic x1_s;
  logic x0_s;

  assign x1_s = ~(a1 ^ b1);
  assign x0_s = ~(a0 ^ b0);
  assign gt   = (a1 & ~b1) | (x1_s & a0 & ~b0);
  assign lt   = (~a1 & b1) | (x1_s & ~a0 & b0);
  assign eq   = x1_s & x0_s;
endmodule

// File: rtl/serial_mag_comp.sv
// MSB-first serial magnitude comparator, one 2-bit slice per clock.
// Define SERIAL_MAG_COMP_EARLY_EXIT_EN to finish on the first unequal slice.
module serial_mag_comp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_mag_comp_if.slave bus
);
  localparam int NS = nslices(WIDTH);
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             dir_gt_q, dir_gt_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic s_lt, s_gt, s_eq;
  logic res_lt_s, res_gt_s, res_dec_s;
  logic exit_early_s;

  twobit_com u_slice (
    .a1 (a_q[WIDTH-1]),
    .a0 (a_q[WIDTH-2]),
    .b1 (b_q[WIDTH-1]),
    .b0 (b_q[WIDTH-2]),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  // An earlier deciding slice always wins over the current one.
  assign res_dec_s = dec_q | ~s_eq;
  assign res_lt_s  = dec_q ? ~dir_gt_q : s_lt;
  assign res_gt_s  = dec_q ? dir_gt_q  : s_gt;

`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
  assign exit_early_s = ~s_eq;
`else
  assign exit_early_s = 1'b0;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    dir_gt_d = dir_gt_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          cnt_d    = CW'(NS - 1);
          dec_d    = 1'b0;
          dir_gt_d = 1'b0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q << SLICE_W;
        b_d      = b_q << SLICE_W;
        cnt_d    = cnt_q - CW'(1);
        dec_d    = res_dec_s;
        dir_gt_d = res_gt_s;
        if ((cnt_q == {CW{1'b0}}) || exit_early_s) begin
          lt_d    = res_dec_s & res_lt_s;
          gt_d    = res_dec_s & res_gt_s;
          eq_d    = ~res_dec_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      dec_q    <= 1'b0;
      dir_gt_q <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      dec_q    <= dec_d;
      dir_gt_q <= dir_gt_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Multi-cycle magnitude comparator that consumes per-slice lt/gt/eq from a 2-bit slice comparator.
- Compares two WIDTH-bit operands MSB-first, one 2-bit slice per clock, and accumulates a single registered lt/gt/eq verdict.
- Sits downstream of the gate-level 2-bit comparator and drives the control logic that needs a wide compare with a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. NS = WIDTH/2 is the number of slices.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; lt/gt/eq are valid from this cycle on.
- lt  output  1  a < b (registered, held until the next done).
- gt  output  1  a > b (registered, held).
- eq  output  1  a == b (registered, held).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, lt=0, gt=0, eq=0, shift registers=0, slice counter=0.
- States:
  - IDLE: start=1 at edge t loads a/b into shift registers, sets cnt=NS-1 and moves to RUN. lt/gt/eq keep their last values.
  - RUN: each edge evaluates the top 2 bits of the A and B registers through the slice comparator, then shifts both registers left by 2 and decrements cnt.
    - The first slice with lt or gt sets a sticky decided flag plus its direction. Later slices never override it.
    - Leave RUN when cnt==0, or on a deciding slice if EARLY_EXIT_EN is defined.
    - On that edge, lt/gt/eq are written from the sticky flag; eq=1 only if no slice decided. Then move to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Invariant: exactly one of lt/gt/eq is 1 after the first completed compare.
- Latency (no early exit): slices evaluated at edges t+1..t+NS; done is high in the cycle after edge t+NS; IDLE is re-entered at t+NS+1.
- Throughput: earliest next accepted start is edge t+NS+2, i.e. one operation per NS+2 cycles with start held high.
- start during RUN or DONE is ignored; a/b changes while busy have no effect.
- Reset asserted mid-operation aborts immediately with no done pulse; all outputs return to reset values.
- WIDTH=2 case: a single RUN cycle.

Optional Feature:
- Macro: SERIAL_MAG_COMP_EARLY_EXIT_EN.
- Defined: RUN exits on the first slice whose eq=0. Latency is k edges for a decision at slice k (k=1 is the MSB slice). Unequal operands finish early; equal operands still take NS.
- Undefined: always NS RUN cycles, giving fixed latency. Results are identical in both builds.

Decomposition:
- Package serial_cmp_pkg holds:
  - typedef cmp_state_t {IDLE, RUN, DONE};
  - localparam SLICE_W=2;
  - function nslices(width)=width/2.
- Sub-module: instantiate the existing 2-bit gate-level comparator twobit_com once as the slice evaluator (inputs a1/a0/b1/b0 from the register MSBs). No other sub-modules.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'hA5, start pulse at edge t -> done high after edge t+4, eq=1, lt=0, gt=0, busy low after edge t+5.
- a=8'h3C, b=8'h40 -> lt=1, gt=0, eq=0. With EARLY_EXIT_EN, done follows edge t+1; without it, done follows edge t+4.
- a=8'hFF, b=8'hFE (differ only in the LSB slice) -> gt=1, with done after edge t+4 in both builds.
- Compare a=8'h01 vs b=8'h02, then pulse start with a=8'hFF, b=8'h00 during RUN -> second start ignored; result lt=1 and only one done pulse.
- rst_n low for one cycle during RUN -> outputs go to 0 asynchronously with no done pulse. A subsequent start with a=8'h10, b=8'h10 gives eq=1 after normal latency.
- start held high for 20 cycles with fixed operands (no early exit) -> done pulses every 6 cycles; lt/gt/eq stable and held between pulses.
